// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types and default sizing for the round-robin multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Requester/consumer bundle of the shared multiplier scheduler.
interface mult_rr_scheduler_if
  import mult_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_bus;
  logic [NREQ*W-1:0] b_bus;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [2*W-1:0]    res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  modport master (
    output req, a_bus, b_bus, res_ready,
    input  gnt, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req, a_bus, b_bus, res_ready,
    output gnt, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/mult_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of req searched cyclically from ptr.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  int unsigned k;
  logic        found;

  always_comb begin
    any   = |req;
    idx   = '0;
    k     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!found && req[IDW'(k)]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one unsigned WxW multiplier between NREQ requesters via round-robin arbitration.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W
) (
  input logic                clk,
  input logic                rst,
  mult_rr_scheduler_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned PW  = 2 * W;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [W-1:0]    a_q, a_nxt;
  logic [W-1:0]    b_q, b_nxt;
  logic [IDW-1:0]  id_q, id_nxt;
  logic [NREQ-1:0] gnt_q, gnt_nxt;
  logic            valid_q, valid_nxt;
  logic [PW-1:0]   data_q, data_nxt;
  logic [IDW-1:0]  rid_q, rid_nxt;
  logic            busy_q, busy_nxt;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      id_q    <= id_nxt;
      gnt_q   <= gnt_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      rid_q   <= rid_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Capture in IDLE, multiply in CALC, hold the result in RESP until accepted.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    a_nxt     = a_q;
    b_nxt     = b_q;
    id_nxt    = id_q;
    gnt_nxt   = '0;
    valid_nxt = valid_q;
    data_nxt  = data_q;
    rid_nxt   = rid_q;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          a_nxt              = bus.a_bus[32'(pick_idx)*W +: W];
          b_nxt              = bus.b_bus[32'(pick_idx)*W +: W];
          id_nxt             = pick_idx;
          gnt_nxt[pick_idx]  = 1'b1;
          ptr_nxt            = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDW'(1);
          state_nxt          = CALC;
        end
      end
      CALC: begin
        data_nxt  = PW'(a_q) * PW'(b_q);
        rid_nxt   = id_q;
        valid_nxt = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = data_q;
  assign bus.res_id    = rid_q;
  assign bus.busy      = busy_q;

endmodule
